// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative radix-2 divider: op encodings, FSM states
// and the iteration count.
package iter_divider_pkg;

   localparam logic [1:0] DIV_OP_NONE     = 2'b00;
   localparam logic [1:0] DIV_OP_UNSIGNED = 2'b01;
   localparam logic [1:0] DIV_OP_SIGNED   = 2'b10;

   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } div_state_e;

endpackage

// File: rtl/iter_divider.sv
// 32-bit iterative restoring divider (signed/unsigned), one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips the iterations and finishes in one cycle.
module iter_divider
   import iter_divider_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [63:0] result,
   output logic        done
);

   div_state_e  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [32:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvsr_q, dvsr_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [63:0] result_q, result_d;

   logic        accept;
   logic        is_signed;
   logic [33:0] rem_shift;
   logic [33:0] step_diff;
   logic        step_ge;
   logic [32:0] step_rem;
   logic [31:0] step_quo;

   function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
      return neg ? (32'd0 - v) : v;
   endfunction

   // Restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_shift = {rem_q, quo_q[31]};
      step_diff = rem_shift - {2'b00, dvsr_q};
      step_ge   = ~step_diff[33];
      step_rem  = step_ge ? step_diff[32:0] : rem_shift[32:0];
      step_quo  = {quo_q[30:0], step_ge};
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvsr_d    = dvsr_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      is_signed = (div_op == DIV_OP_SIGNED);
      accept    = (state_q == ST_IDLE) &&
                  ((div_op == DIV_OP_SIGNED) || (div_op == DIV_OP_UNSIGNED));

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               quo_d     = cond_neg(is_signed & dividend[31], dividend);
               dvsr_d    = cond_neg(is_signed & divisor[31], divisor);
               neg_quo_d = is_signed & (dividend[31] ^ divisor[31]);
               neg_rem_d = is_signed & dividend[31];
               rem_d     = '0;
               cnt_d     = '0;
               state_d   = ST_CALC;
`ifdef DIV_ZERO_FAST_EN
               // Raw operands pass straight through FIX with no sign correction.
               if (divisor == 32'd0) begin
                  rem_d     = {1'b0, dividend};
                  quo_d     = '1;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  state_d   = ST_FIX;
               end
`endif
            end
         end
         ST_CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'(DIV_ITERS - 1)) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            result_d = {cond_neg(neg_rem_q, rem_q[31:0]), cond_neg(neg_quo_q, quo_q)};
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         result_q <= result_d;
      end
   end

   // Operand and sign registers are only meaningful after an accept, so they carry no reset.
   always_ff @(posedge clk) begin
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
   end

   assign result = result_q;
   assign done   = (state_q == ST_IDLE);

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_iter_divider;

   logic        clk;
   logic        rst;
   logic [1:0]  div_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [63:0] result;
   logic        done;

   int checks   = 0;
   int failures = 0;

   iter_divider dut (
      .clk      (clk),
      .rst      (rst),
      .div_op   (div_op),
      .dividend (dividend),
      .divisor  (divisor),
      .result   (result),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] ma, mb, qm, rm, q, r;
      bit nq, nr;
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return {a, 32'hFFFFFFFF};
`endif
      ma = (sgn && a[31]) ? (32'd0 - a) : a;
      mb = (sgn && b[31]) ? (32'd0 - b) : b;
      if (mb == 32'd0) begin
         qm = 32'hFFFFFFFF;
         rm = ma;
      end else begin
         qm = ma / mb;
         rm = ma % mb;
      end
      nq = sgn && (a[31] ^ b[31]);
      nr = sgn && a[31];
      q  = nq ? (32'd0 - qm) : qm;
      r  = nr ? (32'd0 - rm) : rm;
      return {r, q};
   endfunction

   function automatic int model_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      if (b == 32'd0) return 1;
`endif
      return 33;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, count done-low cycles, then check latency and result.
   // hold_junk keeps div_op=signed with new operands asserted through the busy period.
   task automatic run_op(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit hold_junk);
      logic [63:0] prev;
      int n;
      @(negedge clk);
      check({tag, "_ready"}, {63'd0, done}, 64'd1);
      prev     = result;
      div_op   = sgn ? 2'b10 : 2'b01;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      if (hold_junk) begin
         div_op   = 2'b10;
         dividend = $urandom;
         divisor  = $urandom | 32'd1;
      end else begin
         div_op   = 2'b00;
         dividend = $urandom;
         divisor  = $urandom;
      end
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         if (n == 10) check({tag, "_hold"}, result, prev);
         @(posedge clk);
         #1;
         n++;
      end
      div_op = 2'b00;
      check({tag, "_lat"}, 64'(n), 64'(model_lat(b)));
      check({tag, "_res"}, result, model(sgn, a, b));
   endtask

   initial begin
      logic [31:0] ra, rb;
      bit          rs;
      int          n;
      rst      = 1'b1;
      div_op   = 2'b00;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", {63'd0, done}, 64'd1);
      check("reset_result", result, 64'd0);
      rst = 1'b0;

      run_op("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
      check("u100_7_const", result, 64'h00000002_0000000E);
      run_op("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
      check("s_m7_2_const", result, 64'hFFFFFFFF_FFFFFFFD);
      run_op("u_m7_2", 1'b0, 32'hFFFFFFF9, 32'd2, 1'b0);
      check("u_m7_2_const", result, 64'h00000001_7FFFFFFC);
      run_op("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("s_min_m1_const", result, 64'h00000000_80000000);
      run_op("u_div0", 1'b0, 32'h12345678, 32'd0, 1'b0);
      check("u_div0_const", result, 64'h12345678_FFFFFFFF);
      run_op("s_div0_neg", 1'b1, 32'h87654321, 32'd0, 1'b0);
      run_op("s_neg_neg", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0);
      run_op("idle_11_prev", 1'b0, 32'd9, 32'd3, 1'b0);

      // Opcode 2'b11 must be ignored as idle.
      @(negedge clk);
      div_op   = 2'b11;
      dividend = 32'd50;
      divisor  = 32'd5;
      @(posedge clk);
      #1;
      check("op11_done", {63'd0, done}, 64'd1);
      div_op = 2'b00;

      // Ops issued during CALC are ignored; back-to-back accept follows.
      run_op("busy_ign", 1'b1, 32'hFFFF0000, 32'd3, 1'b1);
      run_op("b2b", 1'b0, 32'hDEADBEEF, 32'd16, 1'b0);

      // Reset mid-operation aborts without writing a result.
      @(negedge clk);
      div_op   = 2'b01;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      div_op = 2'b00;
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy", {63'd0, done}, 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_done", {63'd0, done}, 64'd1);
      check("abort_result", result, 64'd0);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("abort_no_write", result, 64'd0);
      run_op("post_rst", 1'b1, 32'hFFFFFC18, 32'd7, 1'b0);

      for (int i = 0; i < 24; i++) begin
         rs = 1'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(1, 15));
            1: rb = 32'd0 - 32'($urandom_range(1, 15));
            2: rb = (i % 6 == 0) ? 32'd0 : $urandom;
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         run_op($sformatf("rnd%0d", i), rs, ra, rb, 1'(i % 5 == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 Port clk, input, 1: clock; all state changes on rising edge.
REQ-002 Port rst, input, 1: reset, synchronous, active-high.
REQ-003 Port div_op, input, 2: 2'b10 signed divide, 2'b01 unsigned divide, 2'b00 idle; 2'b11 treated as idle.
REQ-004 Port dividend, input, 32: numerator, sampled at accept edge only.
REQ-005 Port divisor, input, 32: denominator, sampled at accept edge only.
REQ-006 Port result, output, 64: {remainder[63:32], quotient[31:0]}, registered.
REQ-007 Port done, output, 1: high when idle and ready; low while an operation is in flight.

Function
REQ-008 States IDLE, CALC, FIX; done SHALL be 1 exactly when state is IDLE.
REQ-009 Accept: rising edge with state IDLE and div_op in {2'b10, 2'b01}; latch operands and signedness, clear iteration counter, go to CALC.
REQ-010 div_op while in CALC or FIX SHALL be ignored; no queuing.
REQ-011 Signed op: operate on magnitudes; quotient negated iff dividend[31] XOR divisor[31]; remainder negated iff dividend[31].
REQ-012 CALC: one restoring radix-2 step per cycle on 32-bit magnitudes with a 33-bit partial remainder; 6-bit counter 0..31; after step 31, go to FIX.
REQ-013 FIX: apply sign correction, write result, go to IDLE; done rises after this edge.
REQ-014 Latency: accept edge E0, result valid and done high after edge E33 (34 total edges, 33 cycles with done low).
REQ-015 result SHALL hold its last value in IDLE until the next FIX write; result is not modified during CALC.
REQ-016 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000, remainder 0 (two's-complement wrap, no exception).
REQ-017 Divisor 0 without the fast path: quotient magnitude 0xFFFFFFFF, remainder magnitude |dividend|, then REQ-011 sign correction applies.
REQ-018 Accept in the same cycle done rises is legal: a new op on the cycle after E33 is accepted normally.

Reset
REQ-019 rst SHALL force state IDLE, done=1, result=64'h0, counter=0, partial remainder=0.
REQ-020 rst during CALC or FIX SHALL abort the operation with no result write; rst has priority over accept.

Configuration
REQ-021 Macro DIV_ZERO_FAST_EN defined: divisor==0 at accept goes directly to FIX; result={dividend, 32'hFFFFFFFF} regardless of signedness; done high after E1.
REQ-022 Macro undefined: divisor 0 takes the full 33-cycle path and result per REQ-017.

Structure
REQ-023 Shared package holds div_op encodings (DIV_OP_NONE, DIV_OP_UNSIGNED, DIV_OP_SIGNED), the state enum, and DIV_ITERS=32.
REQ-024 Single module; no sub-module. The step is a combinational block inside.

Verification
REQ-025 Unsigned 100/7 -> done low 33 cycles, then result=64'h00000002_0000000E.
REQ-026 Signed 0xFFFFFFF9 / 2 -> result=64'hFFFFFFFF_FFFFFFFD; unsigned same operands -> 64'h00000001_7FFFFFFC.
REQ-027 Signed 0x80000000 / 0xFFFFFFFF -> result=64'h00000000_80000000.
REQ-028 Divisor 0, dividend 0x12345678, unsigned -> with macro, result=64'h12345678_FFFFFFFF after E1; without macro, same value after E33.
REQ-029 rst asserted 10 cycles after accept -> done=1 and result=0 next cycle; an op issued after reset completes correctly.
REQ-030 div_op=2'b10 with new operands held during CALC -> ignored; the first op's result is unchanged; back-to-back op accepted on the first done-high cycle.
